// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the pushbutton debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        PRS   = 2'd2,
        CHK_R = 2'd3
    } btn_state_e;

    localparam int unsigned DEBOUNCE_25MHZ_10MS = 250000;
    localparam int unsigned LONG_25MHZ_500MS    = 12500000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pad inputs, with a
// parameterized value loaded under synchronous active-low reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync1;
    logic sync2;

    // NOTE: state is updated with <= so both flops sample the pre-edge values
    // and form a true two-stage pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end

    assign q = sync2;

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer + saturating-counter debouncer with press/release
// strobes and a wrapping press counter. Long-press strobe: BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_25MHZ_10MS,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned PRESS_CNT_W     = 8,
    parameter int unsigned LONG_CYCLES     = LONG_25MHZ_500MS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_raw,
    output logic                   pressed,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic [PRESS_CNT_W-1:0] press_count,
    output logic                   long_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic       sync_q;
    logic       lvl;
    btn_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       press_evt, release_evt;
    logic       pressed_q, press_pulse_q, release_pulse_q;
    logic [PRESS_CNT_W-1:0] press_count_q;

    // Reset loads the released pad level so no phantom edge follows reset.
    sync_2ff #(
        .RST_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (sync_q)
    );

    assign lvl = sync_q ^ BTN_ACTIVE_LOW;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        unique case (state_q)
            REL: begin
                if (lvl) begin
                    state_d = CHK_P;
                    cnt_d   = CW'(1);
                end
            end
            CHK_P: begin
                if (!lvl) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = PRS;
                    cnt_d     = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRS: begin
                if (!lvl) begin
                    state_d = CHK_R;
                    cnt_d   = CW'(1);
                end
            end
            CHK_R: begin
                if (lvl) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = REL;
                    cnt_d       = '0;
                    release_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= REL;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            press_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            press_pulse_q   <= press_evt;
            release_pulse_q <= release_evt;
            if (press_evt) begin
                pressed_q     <= 1'b1;
                press_count_q <= press_count_q + 1'b1;
            end else if (release_evt) begin
                pressed_q <= 1'b0;
            end
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign press_count   = press_count_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q;
    logic          long_q;

    // Hold count freezes outside PRS, so a rejected release glitch resumes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else if (press_evt) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else if (state_q == PRS && hold_q != HOLD_MAX) begin
            hold_q <= hold_q + 1'b1;
            long_q <= (hold_q == HOLD_MAX - 1'b1);
        end else begin
            long_q <= 1'b0;
        end
    end

    assign long_pulse = long_q;
`else
    // Feature off: strobe is constant low regardless of LONG_CYCLES.
    assign long_pulse = (LONG_CYCLES == 0) && 1'b0;
`endif

endmodule
